// File: rtl/sram32_burst_ctrl_if.sv
// Bus bundle for the 32-bit SRAM burst controller: command, write and read streams,
// plus the 1w/1r SRAM macro pins.
interface sram32_burst_ctrl_if #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;

    logic              rd_valid;
    logic              rd_ready;
    logic [31:0]       rd_data;

    logic              done;

    logic              CE0;
    logic [ADDR_W-1:0] A0;
    logic [31:0]       D0;
    logic              WE0;
    logic [31:0]       WEM0;
    logic              CE1;
    logic [ADDR_W-1:0] A1;
    logic [31:0]       Q1;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data, wr_strb,
        input  wr_ready,
        input  rd_valid, rd_data,
        output rd_ready,
        input  done
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data, wr_strb,
        output wr_ready,
        output rd_valid, rd_data,
        input  rd_ready,
        output done,
        output CE0, A0, D0, WE0, WEM0, CE1, A1,
        input  Q1
    );

    modport mem (
        input  CE0, A0, D0, WE0, WEM0, CE1, A1,
        output Q1
    );
endinterface

// File: rtl/sram32_burst_ctrl.sv
// Burst controller for a 1w/1r 32-bit SRAM: streams write beats straight to port 0 and
// prefetches reads from port 1 into a 2-entry output FIFO.
module sram32_burst_ctrl #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned LEN_W  = 16
) (
    input logic                CLK,
    input logic                RST,
    sram32_burst_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_count;
    logic              r_done;
    logic              r_inflight;
    logic [31:0]       r_fifo [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_fcount;

    logic              w_wbeat;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic [31:0]       w_wem;

    assign w_wbeat = (r_state == StWrite) && bus.wr_valid;
    assign w_pop   = (r_fcount != 2'd0) && bus.rd_ready;
    assign w_occ   = {1'b0, r_fcount} + {2'b00, r_inflight};
    // A word issued now lands next cycle, so only count what survives this cycle's pop.
    assign w_issue = (r_state == StRead) && (r_count != '0) && (w_occ < 3'd2 + {2'b00, w_pop});

    always_comb begin
        w_wem = '0;
        for (int i = 0; i < 4; i++) begin
            w_wem[8*i +: 8] = {8{bus.wr_strb[i]}};
        end
    end

    assign bus.cmd_ready = (r_state == StIdle) && !RST;
    assign bus.wr_ready  = (r_state == StWrite);
    assign bus.rd_valid  = (r_fcount != 2'd0);
    assign bus.rd_data   = r_fifo[r_rptr];
    assign bus.done      = r_done;

    assign bus.CE0  = w_wbeat;
    assign bus.WE0  = w_wbeat;
    assign bus.A0   = w_wbeat ? r_addr : '0;
    assign bus.D0   = w_wbeat ? bus.wr_data : 32'h0;
    assign bus.WEM0 = w_wbeat ? w_wem : 32'h0;
    assign bus.CE1  = w_issue;
    assign bus.A1   = w_issue ? r_addr : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_fifo[0]  <= 32'h0;
            r_fifo[1]  <= 32'h0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_fcount   <= 2'd0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_fifo[r_wptr] <= bus.Q1;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_fcount <= r_fcount + {1'b0, r_inflight} - {1'b0, w_pop};

            unique case (r_state)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        r_addr  <= bus.cmd_addr;
                        r_count <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= bus.cmd_write ? StWrite : StRead;
                        end
                    end
                end
                StWrite: begin
                    if (w_wbeat) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_count <= r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1)) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (w_issue) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_count <= r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1)) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_pop && (r_fcount == 2'd1) && !r_inflight) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule
